dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU MEM stage (cpu_*) and a DMA/debug loader (dma_*).
- Drives the memory's MemAddr/Memdata/MemWrite/dmCon and returns Memout to both requesters.
- The CPU has priority. A granted DMA burst holds the memory until it ends or hits a length cap. A starvation counter guarantees DMA progress.

Parameters:
- MAX_BURST, 8, max consecutive DMA beats per ownership; minimum 1.
- STARVE_LIMIT, 4, consecutive denied DMA-request cycles before DMA gets priority; minimum 1.

Ports:
- Clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_con  in  2  size: 0 word, 1 half, 2 byte, 3 illegal.
- cpu_gnt  out  1  CPU access performed this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rdata  out  32  read word, valid when cpu_gnt.
- dma_req, dma_we, dma_addr[31:0], dma_wdata[31:0], dma_con[1:0]  in  same meanings as the CPU signals.
- dma_last  in  1  final beat of the DMA burst.
- dma_gnt  out  1  DMA beat performed this cycle.
- dma_rdata  out  32  read word, valid when dma_gnt.
- dm_addr  out  32  to memory MemAddr.
- dm_wdata  out  32  to memory Memdata.
- dm_we  out  1  to memory MemWrite.
- dm_con  out  2  to memory dmCon.
- dm_rdata  in  32  from memory Memout (combinational read).
- err  out  1  sticky: an illegal write (con==3) was attempted.

Behaviour:
- Registered state: st {IDLE, DMA_OWN}, beat_cnt, starve_cnt, err. Grants are combinational from registered state and current requests. Memory access completes in the grant cycle: the read is combinational, the write lands on the next Clk edge.
- Reset (synchronous): st=IDLE, beat_cnt=0, starve_cnt=0, err=0. Reset overrides everything, including mid-burst; a DMA burst in progress is abandoned.
- Grant rule when st=IDLE:
  - If dma_req and starve_cnt==STARVE_LIMIT: dma_gnt.
  - Else if cpu_req: cpu_gnt.
  - Else if dma_req: dma_gnt.
- Grant rule when st=DMA_OWN: dma_gnt=dma_req; cpu_gnt=0.
- cpu_gnt and dma_gnt are never both 1.
- Mux:
  - Granted requester drives dm_addr/dm_wdata/dm_con. dm_we = granted we & (con!=3).
  - No grant: dm_we=0, dm_addr/dm_wdata/dm_con=0.
- Read data: cpu_rdata = dma_rdata = dm_rdata unconditionally; meaningful only with the matching gnt.
- err: set on any granted write with con==3. The write is suppressed. err is cleared only by reset.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each cycle dma_req & ~dma_gnt.
  - Cleared on any dma_gnt cycle.
  - Held when dma_req=0.
- State transitions on a dma_gnt beat, with b = beat_cnt+1:
  - If dma_last or b==MAX_BURST: st=IDLE, beat_cnt=0.
  - Else: st=DMA_OWN, beat_cnt=b.
- DMA_OWN with dma_req=0: release, st=IDLE, beat_cnt=0, no grant that cycle.
- MAX_BURST=1: every DMA beat returns to IDLE.
- After a cap-forced release, a waiting CPU wins the next cycle unless starve_cnt is saturated. starve_cnt was cleared by the beat, so the CPU wins.
- Requester inputs must stay stable while req=1 and gnt=0.

Decomposition:
- Shared package holds:
  - dmCon encodings: DM_WORD=0, DM_HALF=1, DM_BYTE=2, DM_BAD=3.
  - Arbiter state encoding: IDLE=0, DMA_OWN=1.
- No sub-module. The request mux is inline. The counters use $clog2-sized widths derived from the parameters.

Test Plan:
1. CPU only: cpu_req=1, we=1, addr=0x10, wdata=0xDEADBEEF, con=0 for 1 cycle → cpu_gnt=1, cpu_stall=0, dm_we=1, dm_addr=0x10. Next cycle, a read of 0x10 gives cpu_rdata=0xDEADBEEF.
2. Simultaneous requests in IDLE, starve_cnt=0 → cpu_gnt=1, dma_gnt=0, starve_cnt becomes 1. CPU held 4 cycles → starve_cnt=4. On the 5th cycle dma_gnt=1, cpu_stall=1.
3. DMA burst of 3 beats with dma_last on beat 3, CPU requesting from beat 2 → cpu_stall=1 on beats 2-3, cpu_gnt=1 on the cycle after beat 3.
4. DMA holds dma_req for 12 beats without dma_last, MAX_BURST=8, CPU waiting → 8 dma_gnt beats, then 1 cpu_gnt, then DMA resumes.
5. Illegal write: cpu_we=1, cpu_con=3, granted → dm_we=0, err=1 from the next cycle and stays 1 until reset.
6. Reset asserted during DMA beat 2 of 5 → next cycle st=IDLE, all grants follow the IDLE rule, err=0, and a pending CPU request is granted immediately.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: memory access sizes and arbiter states.
package dm_arbiter_pkg;

  localparam logic [1:0] DM_WORD = 2'd0;
  localparam logic [1:0] DM_HALF = 2'd1;
  localparam logic [1:0] DM_BYTE = 2'd2;
  localparam logic [1:0] DM_BAD  = 2'd3;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StDmaOwn = 1'b1
  } arb_state_e;

  // Size codes the memory cannot perform; writes with these are dropped.
  function automatic logic is_bad_con(logic [1:0] con);
    return con == DM_BAD;
  endfunction

endpackage

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU has priority, DMA bursts hold
// ownership up to MAX_BURST beats, and a starvation counter forces DMA through eventually.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        reset,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_con,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_con,
  input  logic        dma_last,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,

  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic [1:0]  dm_con,
  input  logic [31:0] dm_rdata,

  output logic        err
);

  localparam int unsigned BeatW   = $clog2(MAX_BURST + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  localparam logic [BeatW-1:0]   BeatCap   = BeatW'(MAX_BURST);
  localparam logic [StarveW-1:0] StarveSat = StarveW'(STARVE_LIMIT);

  arb_state_e          st_q, st_d;
  logic [BeatW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
  logic                err_q, err_d;

  logic                sel_we;
  logic [1:0]          sel_con;
  logic [BeatW-1:0]    beat_next;

  // State register
  always_ff @(posedge Clk) begin
    if (reset) begin
      st_q         <= StIdle;
      beat_cnt_q   <= '0;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      st_q         <= st_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
    end
  end

  // Output logic: grants from registered state and live requests, then the request mux.
  always_comb begin
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    sel_we   = 1'b0;
    sel_con  = DM_WORD;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_con   = DM_WORD;

    unique case (st_q)
      StIdle: begin
        if (dma_req && (starve_cnt_q == StarveSat)) begin
          dma_gnt = 1'b1;
        end else if (cpu_req) begin
          cpu_gnt = 1'b1;
        end else if (dma_req) begin
          dma_gnt = 1'b1;
        end
      end
      StDmaOwn: dma_gnt = dma_req;
      default: ;
    endcase

    if (cpu_gnt) begin
      sel_we   = cpu_we;
      sel_con  = cpu_con;
      dm_addr  = cpu_addr;
      dm_wdata = cpu_wdata;
      dm_con   = cpu_con;
    end else if (dma_gnt) begin
      sel_we   = dma_we;
      sel_con  = dma_con;
      dm_addr  = dma_addr;
      dm_wdata = dma_wdata;
      dm_con   = dma_con;
    end

    dm_we     = sel_we & ~is_bad_con(sel_con);
    cpu_stall = cpu_req & ~cpu_gnt;
    cpu_rdata = dm_rdata;
    dma_rdata = dm_rdata;
    err       = err_q;
  end

  // Next-state logic
  always_comb begin
    st_d         = st_q;
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    err_d        = err_q;
    beat_next    = beat_cnt_q + 1'b1;

    if ((cpu_gnt || dma_gnt) && sel_we && is_bad_con(sel_con)) begin
      err_d = 1'b1;
    end

    if (dma_gnt) begin
      starve_cnt_d = '0;
    end else if (dma_req && (starve_cnt_q != StarveSat)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    if (dma_gnt) begin
      if (dma_last || (beat_next == BeatCap)) begin
        st_d       = StIdle;
        beat_cnt_d = '0;
      end else begin
        st_d       = StDmaOwn;
        beat_cnt_d = beat_next;
      end
    end else if (st_q == StDmaOwn) begin
      // Owner dropped its request: give the memory back without a grant this cycle.
      st_d       = StIdle;
      beat_cnt_d = '0;
    end
  end

endmodule
